// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The address-legality rule lives here so the FSM and any future cache front end agree on it.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  // A request is legal when exactly one of read/write is set, it is word aligned and in range.
  function automatic logic addr_legal(
    input logic [31:0] addr,
    input logic        rd,
    input logic        wr,
    input int unsigned depth_words
  );
    logic [33:0] limit_s;
    limit_s = {depth_words[31:0], 2'b00};
    return (rd ^ wr) && (addr[1:0] == 2'b00) && ({2'b00, addr} < limit_s);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: combinational read, byte-enabled synchronous write.
// Deliberately has no reset so contents survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

  assign rdata = mem_r[addr];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store-port slave: accepts one request at a time, waits a fixed latency,
// then answers with a one-cycle ack carrying read data or an error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] data_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic              op_write_r;
  logic [AW-1:0]     waddr_r;
  logic [WORD_W-1:0] wdata_r;
  logic [BE_W-1:0]   be_r;
  logic [WORD_W-1:0] data_r;
  logic              ack_r;
  logic              err_r;
  logic              busy_r;

  logic              last_s;
  logic              commit_s;
  logic [WORD_W-1:0] rdata_s;

  // A reset landing on the final wait edge must still suppress the write.
  assign last_s   = (state_r == WAIT) && (cnt_r == CW'(0));
  assign commit_s = last_s && op_write_r && rst_i;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk_i),
    .we   (commit_s),
    .addr (waddr_r),
    .wdata(wdata_r),
    .be   (be_r),
    .rdata(rdata_s)
  );

  // Request FSM with latency counter, latched attributes and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= CW'(0);
      op_write_r <= 1'b0;
      waddr_r    <= AW'(0);
      wdata_r    <= 32'h0000_0000;
      be_r       <= 4'b0000;
      data_r     <= 32'h0000_0000;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i) begin
            busy_r <= 1'b1;
            if (addr_legal(addr_i, memread_i, memwrite_i, DEPTH_WORDS)) begin
              op_write_r <= memwrite_i;
              waddr_r    <= addr_i[AW+1:2];
              wdata_r    <= data_i;
              be_r       <= be_i;
              cnt_r      <= CW'(LATENCY - 1);
              state_r    <= WAIT;
            end else begin
              ack_r   <= 1'b1;
              err_r   <= 1'b1;
              state_r <= RESP;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        WAIT: begin
          if (last_s) begin
            ack_r   <= 1'b1;
            err_r   <= 1'b0;
            state_r <= RESP;
            if (!op_write_r) begin
              data_r <= rdata_s;
            end
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        RESP: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign data_o = data_r;
  assign ack_o  = ack_r;
  assign err_o  = err_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  be_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_q;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LATENCY)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .memread_i (memread_i),
    .memwrite_i(memwrite_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .be_i      (be_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: word array plus the last successfully read word.
  task automatic model_step(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output bit e_err, output logic [31:0] e_data);
    bit legal;
    legal = (rd != wr) && (a % 4 == 0) && (a < 4 * DEPTH);
    if (legal) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_m[a / 4][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_q = mem_m[a / 4];
      end
    end
    e_err  = !legal;
    e_data = exp_q;
  endtask

  // Drive one request from IDLE, wait for its ack, check timing/err/data, return to IDLE.
  task automatic run_txn(input string name, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input bit scramble, input bit e_err, input logic [31:0] e_data);
    int  n;
    bit  got;
    bit  busy1;
    req_i = 1'b1; memread_i = rd; memwrite_i = wr; addr_i = a; data_i = wd; be_i = be;
    n = 0; got = 1'b0; busy1 = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      if (i == 0) busy1 = busy_o;
      if (ack_o) got = 1'b1;
      else if (scramble) begin
        addr_i = $urandom; data_i = $urandom; be_i = 4'($urandom);
        memread_i = 1'($urandom); memwrite_i = 1'($urandom);
      end
    end
    chk({name, " ack_seen"}, 32'(got), 32'd1);
    chk({name, " busy_after_accept"}, 32'(busy1), 32'd1);
    chk({name, " ack_edges"}, 32'(n), e_err ? 32'd1 : 32'(LATENCY + 1));
    chk({name, " err"}, 32'(err_o), 32'(e_err));
    chk({name, " data"}, data_o, e_data);
    req_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    @(posedge clk); #1;
    chk({name, " ack_drop"}, 32'(ack_o), 32'd0);
    chk({name, " busy_drop"}, 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit          e_err;
    logic [31:0] e_data;
    logic [31:0] pool [8];
    int          ack_cyc [4];
    int          nacks, low, cyc;
    bit          ack_any;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 4'b1111, 1'b1, 32'hDE22_BE44};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'b1111, 1'b1, 32'hDE22_BE44};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b1, 32'hDE22_BE44};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'hDE22_BE44};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 32'hDE22_BE44};
    tbl[10] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b1, 32'hDE22_BE44};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h5A5A_1234, 4'b1111, 1'b0, 32'hDE22_BE44};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'b1111, 1'b0, 32'h5A5A_1234};
    tbl[13] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1111, 1'b1, 32'h5A5A_1234};

    exp_q = 32'h0000_0000;
    rst_i = 1'b0; req_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    addr_i = 32'h0; data_i = 32'h0; be_i = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset ack", 32'(ack_o), 32'd0);
    chk("reset err", 32'(err_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset data", data_o, 32'h0000_0000);
    rst_i = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, e_err, e_data);
      run_txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
              tbl[i].be, 1'b0, tbl[i].e_err, tbl[i].e_data);
    end

    // Reset two edges after accepting a write: no ack, no commit, outputs cleared.
    req_i = 1'b1; memwrite_i = 1'b1; memread_i = 1'b0;
    addr_i = 32'h0000_0010; data_i = 32'hCAFE_F00D; be_i = 4'b1111;
    ack_any = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    if (ack_o) ack_any = 1'b1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst ack", 32'(ack_o), 32'd0);
    chk("midrst err", 32'(err_o), 32'd0);
    chk("midrst busy_clr", 32'(busy_o), 32'd0);
    chk("midrst data", data_o, 32'h0000_0000);
    @(posedge clk); #1;
    req_i = 1'b0; memwrite_i = 1'b0; rst_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_o) ack_any = 1'b1;
    end
    chk("midrst no_ack", 32'(ack_any), 32'd0);
    exp_q = 32'h0000_0000;
    model_step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, e_err, e_data);
    run_txn("midrst readback", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, e_err, e_data);
    chk("midrst model", e_data, 32'hDE22_BE44);

    // Held request, alternating reads: acks 6 edges apart, one idle cycle between.
    req_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h0000_0010;
    nacks = 0; low = 0; cyc = 0;
    for (int i = 0; i < 60 && nacks < 4; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (nacks > 0 && !busy_o) low++;
      if (ack_o) begin
        model_step(1'b1, 1'b0, addr_i, 32'h0, 4'hF, e_err, e_data);
        chk($sformatf("held data%0d", nacks), data_o, e_data);
        ack_cyc[nacks] = cyc;
        nacks++;
        addr_i = (addr_i == 32'h0000_0010) ? 32'h0000_0FFC : 32'h0000_0010;
      end
    end
    req_i = 1'b0; memread_i = 1'b0;
    chk("held nacks", 32'(nacks), 32'd4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("held gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(LATENCY + 2));
    chk("held busy_low", 32'(low), 32'd3);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 8; i++) begin
      pool[i] = (i == 7) ? 32'h0000_0FFC : 32'h0000_0100 + 32'(i * 4);
      model_step(1'b0, 1'b1, pool[i], $urandom, 4'hF, e_err, e_data);
      run_txn($sformatf("init%0d", i), 1'b0, 1'b1, pool[i], mem_m[pool[i] / 4], 4'hF,
              1'b0, e_err, e_data);
    end
    for (int i = 0; i < 150; i++) begin
      bit          rd, wr;
      logic [31:0] a, wd;
      logic [3:0]  be;
      int          kind;
      kind = $urandom_range(0, 9);
      wd = $urandom; be = 4'($urandom);
      a = pool[$urandom_range(0, 7)];
      rd = 1'b1; wr = 1'b0;
      if (kind >= 4 && kind <= 6) begin rd = 1'b0; wr = 1'b1; end
      else if (kind == 7) a = a + 32'($urandom_range(1, 3));
      else if (kind == 8) begin
        a = $urandom;
        if (a < 32'h0000_1000) a = a + 32'h0000_1000;
        a[1:0] = 2'b00;
      end else if (kind == 9) begin
        rd = 1'($urandom); wr = rd;
      end
      model_step(rd, wr, a, wd, be, e_err, e_data);
      run_txn($sformatf("rand%0d", i), rd, wr, a, wd, be, 1'($urandom), e_err, e_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's load/store port; the slave end of the CPU memory request interface.
- Accepts one request at a time (read or write, byte-enabled) and models a fixed multi-cycle memory latency.
- Answers each request with a one-cycle ack pulse carrying read data or an error flag.
- Sits behind the CPU datapath (later behind a cache) in place of the zero-latency data memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 4: edges from request acceptance to ack; must be >= 1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset.
- req_i  in  1  request strobe; held by the initiator, with all attributes stable, until ack_o.
- memread_i  in  1  read request.
- memwrite_i  in  1  write request.
- addr_i  in  32  byte address.
- data_i  in  32  write data.
- be_i  in  4  byte enables; bit n controls data bits [8n+7:8n].
- data_o  out  32  read data, valid while ack_o=1; holds until the next successful read ack.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  error qualifier, valid only with ack_o.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is a synchronous, active-low reset.
- Reset values: ack_o=0, err_o=0, busy_o=0, data_o=0, state=IDLE, counter=0.
- Reset does not clear the memory array.
- States: IDLE, WAIT, RESP.
- IDLE, request sampled (req_i=1 at edge k):
  - Legal request: exactly one of memread_i/memwrite_i is set, addr_i[1:0]==0, and addr_i < 4*DEPTH_WORDS.
  - Legal: latch op, word address, data and be; counter=LATENCY-1; go to WAIT.
  - Illegal: go straight to RESP with err_o=1. No array access; data_o unchanged.
- WAIT: counter decrements each edge. At the edge where counter==0:
  - go to RESP, set ack_o=1 and err_o=0;
  - a write commits the enabled byte lanes to the array on that same edge;
  - a read loads data_o from the array word on that same edge.
- Legal request timing: ack_o is high for the single cycle following edge k+LATENCY.
- Illegal request timing: ack_o is high for the cycle following edge k.
- RESP: at the next edge clear ack_o and err_o and return to IDLE. req_i is ignored in RESP and WAIT.
- Back-to-back: the earliest next acceptance is the edge after returning to IDLE. With req_i held continuously, consecutive legal acks are LATENCY+2 edges apart.
- Write with be_i=0000: completes normally with ack, and the array is unchanged.
- Reset mid-transaction (WAIT or RESP):
  - the transaction is abandoned and no ack is issued;
  - a pending write is never committed;
  - all outputs return to reset values.
- Attribute changes while WAIT are ignored, because the latched copies are used.
- Counter width is clog2(LATENCY+1); word index is addr_i[clog2(DEPTH_WORDS)+1:2].

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the word and byte-enable width constants;
  - an address-legality helper function.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage;
  - combinational read;
  - synchronous byte-enabled write with a write-enable input;
  - no reset.
- The FSM, counter and latches stay in dmem_responder.

Test Plan (LATENCY=4, DEPTH_WORDS=1024):
1. Reset: rst_i=0 for 2 edges -> ack_o=0, err_o=0, busy_o=0, data_o=0x00000000.
2. Write then read:
   - Write 0x00000010 <- 0xDEADBEEF, be_i=1111, accepted at edge k -> busy_o=1 from cycle after k; ack_o=1, err_o=0 exactly in cycle after k+4.
   - Then read 0x00000010 -> ack_o with data_o=0xDEADBEEF.
3. Byte enables: write 0x11223344 with be_i=0101 over 0xDEADBEEF at 0x10 -> subsequent read returns 0xDE22BE44.
4. Errors, each giving ack_o=1 and err_o=1 in the cycle after acceptance, data_o unchanged, array unchanged:
   - misaligned read at 0x00000012;
   - read at 0x00001000 (out of range);
   - both memread_i and memwrite_i set.
5. Reset mid-write: write 0x10 <- 0xCAFEF00D, assert rst_i=0 two edges after acceptance -> no ack_o; later read of 0x10 returns 0xDE22BE44.
6. Held req_i with alternating legal reads -> acks spaced exactly 6 edges apart; busy_o low for exactly one cycle between transactions.
